// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage with valid/ready handshake on both sides.
// The decoded bundle loads on accept and is held until execute consumes it or a flush arrives.
module decode_stage #(
    parameter int unsigned XLEN        = 32,
    parameter bit          SUPPORT_MUL = 1'b0
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            InValid,
    output logic            InReady,
    input  logic [31:0]     Instruction,
    input  logic [XLEN-1:0] InPC,
    input  logic            Flush,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [XLEN-1:0] OutPC,
    output logic [4:0]      RD,
    output logic [4:0]      RS1,
    output logic [4:0]      RS2,
    output logic [XLEN-1:0] DecodedImediate,
    output logic [1:0]      LHSsource,
    output logic [1:0]      RHSsource,
    output logic [3:0]      ALUOperation,
    output logic            WritesRegisterFile,
    output logic            WritesRam,
    output logic            ReadsRam,
    output logic [2:0]      MemWidth,
    output logic            IsBranch,
    output logic            IsJump,
    output logic            MulOp,
    output logic            InvalidInstructionSignal
);

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OPIMM  = 7'b0010011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011
    } opcode_e;

    typedef enum logic [1:0] {
        LHS_RS1  = 2'd0,
        LHS_PC   = 2'd1,
        LHS_ZERO = 2'd2
    } lhs_e;

    typedef enum logic [1:0] {
        RHS_RS2   = 2'd0,
        RHS_IMM   = 2'd1,
        RHS_FOUR  = 2'd2
    } rhs_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [1:0]      lhs;
        logic [1:0]      rhs;
        logic [3:0]      alu;
        logic            wrf;
        logic            wram;
        logic            rram;
        logic [2:0]      memw;
        logic            br;
        logic            jmp;
        logic            mul;
        logic            inv;
    } bundle_t;

    logic    valid_q, valid_d;
    logic    accept;
    bundle_t bundle_q, dec;

    opcode_e         opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            shift_upper_ok;

    assign opcode = opcode_e'(Instruction[6:0]);
    assign f3     = Instruction[14:12];
    assign f7     = Instruction[31:25];

    assign imm_i = {{(XLEN-12){Instruction[31]}}, Instruction[31:20]};
    assign imm_s = {{(XLEN-12){Instruction[31]}}, Instruction[31:25], Instruction[11:7]};
    assign imm_b = {{(XLEN-13){Instruction[31]}}, Instruction[31], Instruction[7],
                    Instruction[30:25], Instruction[11:8], 1'b0};
    assign imm_u = {{(XLEN-32){Instruction[31]}}, Instruction[31:12], 12'b0};
    assign imm_j = {{(XLEN-21){Instruction[31]}}, Instruction[31], Instruction[19:12],
                    Instruction[20], Instruction[30:21], 1'b0};

    // Bit 30 selects SRAI; on RV64 bit 25 is shamt[5], so it is excluded from the zero check.
    always_comb begin
        if (XLEN == 64) shift_upper_ok = ({Instruction[31], Instruction[29:26]} == 5'b0);
        else            shift_upper_ok = ({Instruction[31], Instruction[29:25]} == 6'b0);
        if (Instruction[30] && f3 != 3'b101) shift_upper_ok = 1'b0;
    end

    always_comb begin
        dec      = '0;
        dec.pc   = InPC;
        dec.rd   = Instruction[11:7];
        dec.rs1  = Instruction[19:15];
        dec.rs2  = Instruction[24:20];
        dec.lhs  = LHS_RS1;
        dec.rhs  = RHS_RS2;
        case (opcode)
            OPC_OP: begin
                dec.alu = {Instruction[30], f3};
                dec.wrf = 1'b1;
                if (f7 == 7'b0000000) begin
                    dec.inv = 1'b0;
                end else if (f7 == 7'b0100000) begin
                    dec.inv = !(f3 == 3'b000 || f3 == 3'b101);
                end else if (SUPPORT_MUL && f7 == 7'b0000001) begin
                    dec.alu = {1'b1, f3};
                    dec.mul = 1'b1;
                end else begin
                    dec.inv = 1'b1;
                end
            end
            OPC_OPIMM: begin
                dec.rhs = RHS_IMM;
                dec.imm = imm_i;
                dec.alu = {(f3 == 3'b101) ? Instruction[30] : 1'b0, f3};
                dec.wrf = 1'b1;
                if (f3 == 3'b001 || f3 == 3'b101) dec.inv = !shift_upper_ok;
            end
            OPC_LOAD: begin
                dec.rhs  = RHS_IMM;
                dec.imm  = imm_i;
                dec.rram = 1'b1;
                dec.wrf  = 1'b1;
                dec.memw = f3;
                case (f3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: dec.inv = 1'b0;
                    3'b011, 3'b110:                         dec.inv = (XLEN != 64);
                    default:                                dec.inv = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec.rhs  = RHS_IMM;
                dec.imm  = imm_s;
                dec.wram = 1'b1;
                dec.memw = f3;
                case (f3)
                    3'b000, 3'b001, 3'b010: dec.inv = 1'b0;
                    3'b011:                 dec.inv = (XLEN != 64);
                    default:                dec.inv = 1'b1;
                endcase
            end
            OPC_LUI: begin
                dec.lhs = LHS_ZERO;
                dec.rhs = RHS_IMM;
                dec.imm = imm_u;
                dec.wrf = 1'b1;
            end
            OPC_AUIPC: begin
                dec.lhs = LHS_PC;
                dec.rhs = RHS_IMM;
                dec.imm = imm_u;
                dec.wrf = 1'b1;
            end
            OPC_JAL: begin
                dec.lhs = LHS_PC;
                dec.rhs = RHS_FOUR;
                dec.imm = imm_j;
                dec.jmp = 1'b1;
                dec.wrf = 1'b1;
            end
            OPC_JALR: begin
                dec.lhs = LHS_PC;
                dec.rhs = RHS_FOUR;
                dec.imm = imm_i;
                dec.jmp = 1'b1;
                dec.wrf = 1'b1;
                dec.inv = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec.imm = imm_b;
                dec.alu = 4'b1000;
                dec.br  = 1'b1;
                dec.inv = (f3 == 3'b010 || f3 == 3'b011);
            end
            default: dec.inv = 1'b1;
        endcase
        if (dec.inv) begin
            dec.wrf  = 1'b0;
            dec.wram = 1'b0;
            dec.rram = 1'b0;
            dec.br   = 1'b0;
            dec.jmp  = 1'b0;
            dec.mul  = 1'b0;
        end
        if (dec.rd == 5'd0) dec.wrf = 1'b0;
    end

    assign InReady = !valid_q || OutReady;
    assign accept  = InValid && InReady && !Flush;

    always_comb begin
        valid_d = valid_q;
        if (Flush)         valid_d = 1'b0;
        else if (accept)   valid_d = 1'b1;
        else if (OutReady) valid_d = 1'b0;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            valid_q <= valid_d;
            if (accept) bundle_q <= dec;
        end
    end

    assign OutValid                 = valid_q;
    assign OutPC                    = bundle_q.pc;
    assign RD                       = bundle_q.rd;
    assign RS1                      = bundle_q.rs1;
    assign RS2                      = bundle_q.rs2;
    assign DecodedImediate          = bundle_q.imm;
    assign LHSsource                = bundle_q.lhs;
    assign RHSsource                = bundle_q.rhs;
    assign ALUOperation             = bundle_q.alu;
    assign WritesRegisterFile       = bundle_q.wrf;
    assign WritesRam                = bundle_q.wram;
    assign ReadsRam                 = bundle_q.rram;
    assign MemWidth                 = bundle_q.memw;
    assign IsBranch                 = bundle_q.br;
    assign IsJump                   = bundle_q.jmp;
    assign MulOp                    = bundle_q.mul;
    assign InvalidInstructionSignal = bundle_q.inv;

endmodule
